fifo_axis_drain: RTL and testbench

- Downstream consumer of the 128-bit block FIFO in the AES datapath.
- On a start pulse, pops a programmed number of 128-bit blocks from the FIFO.
- Serialises each block into 32-bit AXI4-Stream beats toward the DMA/S2MM side, asserting tlast on the final beat of the packet.
- Obeys the FIFO's one-cycle read latency and its fifo_ready (no-access-while-busy) rule.

---
 rtl/fifo_axis_drain.sv | 120 ++++++++++++
 tb/tb_fifo_axis_drain.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_drain.sv
// Drains a programmed number of blocks from the AES block FIFO and
// serialises each block MSB-slice-first onto an AXI4-Stream master.
module fifo_axis_drain #(
    parameter int DATA_WIDTH = 128,
    parameter int AXIS_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  blk_count,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_read_e,
    input  logic                  fifo_empty,
    input  logic                  fifo_ready,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int BEATS = DATA_WIDTH / AXIS_WIDTH;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CNT_WIDTH-1:0] ONE_BLK = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_STREAM
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  blocks_left_q, blocks_left_d;
    logic [BW-1:0]         beat_idx_q, beat_idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  done_q, done_d;
    logic                  last_beat;
    logic                  last_blk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            blocks_left_q <= '0;
            beat_idx_q    <= '0;
            shreg_q       <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            blocks_left_q <= blocks_left_d;
            beat_idx_q    <= beat_idx_d;
            shreg_q       <= shreg_d;
            done_q        <= done_d;
        end
    end

    assign last_beat = (beat_idx_q == LAST_BEAT);
    assign last_blk  = (blocks_left_q == ONE_BLK);

    always_comb begin
        state_d       = state_q;
        blocks_left_d = blocks_left_q;
        beat_idx_d    = beat_idx_q;
        shreg_d       = shreg_q;
        done_d        = 1'b0;
        fifo_read_e   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // done_q high means the packet just ended; start is ignored
                if (start && !done_q) begin
                    if (blk_count != '0) begin
                        blocks_left_d = blk_count;
                        state_d       = S_READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (!fifo_empty && fifo_ready) begin
                    fifo_read_e = 1'b1;
                    state_d     = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                shreg_d    = fifo_rdata;
                beat_idx_d = '0;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                if (m_axis_tready) begin
                    shreg_d    = shreg_q << AXIS_WIDTH;
                    beat_idx_d = beat_idx_q + BW'(1);
                    if (last_beat) begin
                        if (last_blk) begin
                            blocks_left_d = '0;
                            done_d        = 1'b1;
                            state_d       = S_IDLE;
                        end else begin
                            blocks_left_d = blocks_left_q - ONE_BLK;
                            state_d       = S_READ;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stream outputs decode straight from state so reset drops them at once
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign m_axis_tvalid = (state_q == S_STREAM);
    assign m_axis_tdata  = shreg_q[DATA_WIDTH-1 -: AXIS_WIDTH];
    assign m_axis_tlast  = (state_q == S_STREAM) && last_beat && last_blk;

endmodule

// File: tb/tb_fifo_axis_drain.sv
// Randomised bench for fifo_axis_drain: FIFO model with one-cycle read
// latency, stream monitor, and a queue-based expected-beat model.
module tb_fifo_axis_drain;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int CW = 16;
    localparam int BEATS = DW / AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] blk_count = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_read_e;
    logic          fifo_empty;
    logic          fifo_ready = 1'b1;
    logic [AW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;

    int checks = 0;
    int errors = 0;

    fifo_axis_drain #(
        .DATA_WIDTH(DW),
        .AXIS_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .blk_count    (blk_count),
        .busy         (busy),
        .done         (done),
        .fifo_rdata   (fifo_rdata),
        .fifo_read_e  (fifo_read_e),
        .fifo_empty   (fifo_empty),
        .fifo_ready   (fifo_ready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data appears the cycle after a read, garbage otherwise
    logic [DW-1:0] mem [0:255];
    logic [7:0]    wr_n = '0;
    logic [7:0]    rd_n = '0;
    logic [DW-1:0] mq [$];
    assign fifo_empty = (wr_n == rd_n);

    always @(posedge clk) begin
        if (fifo_read_e && (wr_n != rd_n)) begin
            fifo_rdata <= mem[rd_n];
            rd_n <= rd_n + 8'd1;
        end else begin
            fifo_rdata <= {$urandom, $urandom, $urandom, $urandom};
        end
    end

    int tr_mode = 0;
    always @(posedge clk) begin
        #1;
        case (tr_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [AW-1:0] obs_d [$];
    logic          obs_l [$];
    int rd_cnt = 0, re_bad = 0, tv_cnt = 0, done_cnt = 0, stab_bad = 0;
    int hs_cyc = 0, done_cyc = 0, tv_rise_cyc = 0;
    bit re_prev = 0, stall_q = 0, tv_prev = 0;
    logic [AW-1:0] stall_d = '0;
    logic stall_l = 1'b0;

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            obs_d.push_back(m_axis_tdata);
            obs_l.push_back(m_axis_tlast);
            hs_cyc = cyc;
        end
        if (stall_q && (!m_axis_tvalid || m_axis_tdata !== stall_d ||
                        m_axis_tlast !== stall_l))
            stab_bad++;
        stall_q = m_axis_tvalid && !m_axis_tready;
        stall_d = m_axis_tdata;
        stall_l = m_axis_tlast;
        if (fifo_read_e) begin
            rd_cnt++;
            if (fifo_empty || !fifo_ready || re_prev) re_bad++;
        end
        re_prev = fifo_read_e;
        if (m_axis_tvalid) tv_cnt++;
        if (m_axis_tvalid && !tv_prev) tv_rise_cyc = cyc;
        tv_prev = m_axis_tvalid;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    logic [AW-1:0] exp_d [$];
    logic          exp_l [$];

    task automatic push_block(input logic [DW-1:0] b);
        mem[wr_n] = b;
        mq.push_back(b);
        wr_n = wr_n + 8'd1;
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++)
            push_block({$urandom, $urandom, $urandom, $urandom});
    endtask

    // Packet of n blocks: MSB slice first, tlast on the very last beat
    task automatic expect_pkt(input int n);
        logic [DW-1:0] b;
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < n; i++) begin
            b = mq.pop_front();
            for (int j = 0; j < BEATS; j++) begin
                exp_d.push_back(b[DW-1-AW*j -: AW]);
                exp_l.push_back((i == n - 1) && (j == BEATS - 1));
            end
        end
    endtask

    task automatic run_packet(input int n, input int mode,
                              output bit to, output int sc);
        int k;
        int dc;
        tr_mode = mode;
        dc = done_cnt;
        blk_count = CW'(n);
        start = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (done_cnt == dc && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        to = (done_cnt == dc);
    endtask

    task automatic wait_done(output bit to);
        int k;
        int dc;
        dc = done_cnt;
        k = 0;
        while (done_cnt == dc && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        to = (done_cnt == dc);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, fifo_read_e, m_axis_tvalid, m_axis_tlast} !== 5'b0 ||
            m_axis_tdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got b%b d%b re%b v%b l%b data %h want all 0",
                     busy, done, fifo_read_e, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        bit to;
        int sc, ob, rd0, rb0;
        push_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
        expect_pkt(1);
        ob = obs_d.size();
        rd0 = rd_cnt;
        rb0 = re_bad;
        run_packet(1, 0, to, sc);
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout: no done"); end
        checks++;
        if (obs_d.size() - ob != exp_d.size()) begin
            errors++;
            $display("FAIL single_len: got %0d beats want %0d", obs_d.size() - ob, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && ob + i < obs_d.size(); i++) begin
            checks++;
            if (obs_d[ob+i] !== exp_d[i] || obs_l[ob+i] !== exp_l[i]) begin
                errors++;
                $display("FAIL single_beat%0d: got %h/%b want %h/%b",
                         i, obs_d[ob+i], obs_l[ob+i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (tv_rise_cyc - sc != 3) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles want 3", tv_rise_cyc - sc);
        end
        checks++;
        if (done_cyc - hs_cyc != 1) begin
            errors++;
            $display("FAIL single_done_delay: got %0d want 1", done_cyc - hs_cyc);
        end
        checks++;
        if (rd_cnt - rd0 != 1 || re_bad != rb0) begin
            errors++;
            $display("FAIL single_reads: got %0d reads, %0d bad want 1, 0",
                     rd_cnt - rd0, re_bad - rb0);
        end
    endtask

    task automatic test_stall;
        bit to;
        int sc, ob, rd0, sb0;
        push_rand(3);
        expect_pkt(3);
        ob = obs_d.size();
        rd0 = rd_cnt;
        sb0 = stab_bad;
        run_packet(3, 1, to, sc);
        checks++;
        if (to) begin errors++; $display("FAIL stall_timeout: no done"); end
        checks++;
        if (obs_d.size() - ob != 12) begin
            errors++;
            $display("FAIL stall_len: got %0d beats want 12", obs_d.size() - ob);
        end
        for (int i = 0; i < exp_d.size() && ob + i < obs_d.size(); i++) begin
            checks++;
            if (obs_d[ob+i] !== exp_d[i] || obs_l[ob+i] !== exp_l[i]) begin
                errors++;
                $display("FAIL stall_beat%0d: got %h/%b want %h/%b",
                         i, obs_d[ob+i], obs_l[ob+i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (stab_bad != sb0 || rd_cnt - rd0 != 3) begin
            errors++;
            $display("FAIL stall_stable_reads: got %0d unstable, %0d reads want 0, 3",
                     stab_bad - sb0, rd_cnt - rd0);
        end
        tr_mode = 0;
    endtask

    task automatic test_empty_wait;
        bit to;
        int ob, rd0, rb0;
        push_rand(1);
        ob = obs_d.size();
        rd0 = rd_cnt;
        rb0 = re_bad;
        tr_mode = 0;
        blk_count = CW'(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (rd_cnt - rd0 != 1 || re_bad != rb0 || busy !== 1'b1 ||
            m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL empty_wait: got reads %0d bad %0d busy %b valid %b want 1 0 1 0",
                     rd_cnt - rd0, re_bad - rb0, busy, m_axis_tvalid);
        end
        push_rand(1);
        expect_pkt(2);
        wait_done(to);
        checks++;
        if (to || obs_d.size() - ob != 8) begin
            errors++;
            $display("FAIL empty_resume: got timeout %b beats %0d want 0 8",
                     to, obs_d.size() - ob);
        end
        for (int i = 0; i < exp_d.size() && ob + i < obs_d.size(); i++) begin
            checks++;
            if (obs_d[ob+i] !== exp_d[i] || obs_l[ob+i] !== exp_l[i]) begin
                errors++;
                $display("FAIL empty_beat%0d: got %h/%b want %h/%b",
                         i, obs_d[ob+i], obs_l[ob+i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_fifo_ready;
        bit to;
        int ob, early;
        fifo_ready = 1'b0;
        push_rand(1);
        expect_pkt(1);
        ob = obs_d.size();
        blk_count = CW'(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        early = 0;
        for (int i = 0; i < 5; i++) begin
            if (fifo_read_e !== 1'b0) early++;
            @(posedge clk); #1;
        end
        checks++;
        if (early != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ready_hold: got %0d reads busy %b want 0 1", early, busy);
        end
        fifo_ready = 1'b1;
        #1;
        checks++;
        if (fifo_read_e !== 1'b1) begin
            errors++;
            $display("FAIL ready_release: got read_e %b want 1", fifo_read_e);
        end
        @(posedge clk); #1;
        wait_done(to);
        checks++;
        if (to || obs_d.size() - ob != 4 || obs_d[ob+3] !== exp_d[3] ||
            obs_d[ob] !== exp_d[0]) begin
            errors++;
            $display("FAIL ready_data: got timeout %b beats %0d want 0 4",
                     to, obs_d.size() - ob);
        end
    endtask

    task automatic test_zero;
        int tv0, rd0;
        tv0 = tv_cnt;
        rd0 = rd_cnt;
        blk_count = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done %b busy %b want 1 0", done, busy);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (tv_cnt != tv0 || rd_cnt != rd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_quiet: got valid %0d reads %0d done %b want 0 0 0",
                     tv_cnt - tv0, rd_cnt - rd0, done);
        end
    endtask

    task automatic test_start_ignored;
        int ob, k, rd0, bz;
        push_rand(3);
        expect_pkt(2);
        ob = obs_d.size();
        tr_mode = 2;
        blk_count = CW'(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        blk_count = CW'(5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        blk_count = CW'(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rd0 = rd_cnt;
        bz = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy !== 1'b0) bz++;
            @(posedge clk); #1;
        end
        checks++;
        if (obs_d.size() - ob != 8) begin
            errors++;
            $display("FAIL busy_start_len: got %0d beats want 8", obs_d.size() - ob);
        end
        for (int i = 0; i < exp_d.size() && ob + i < obs_d.size(); i++) begin
            checks++;
            if (obs_d[ob+i] !== exp_d[i] || obs_l[ob+i] !== exp_l[i]) begin
                errors++;
                $display("FAIL busy_start_beat%0d: got %h/%b want %h/%b",
                         i, obs_d[ob+i], obs_l[ob+i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (bz != 0 || rd_cnt != rd0) begin
            errors++;
            $display("FAIL done_cycle_start: got busy %0d reads %0d want 0 0",
                     bz, rd_cnt - rd0);
        end
        tr_mode = 0;
    endtask

    task automatic test_random;
        bit to;
        int sc, ob, n, sb0;
        for (int it = 0; it < 4; it++) begin
            push_rand($urandom_range(1, 4));
            n = mq.size();
            expect_pkt(n);
            ob = obs_d.size();
            sb0 = stab_bad;
            run_packet(n, 2, to, sc);
            checks++;
            if (to || obs_d.size() - ob != 4 * n || stab_bad != sb0) begin
                errors++;
                $display("FAIL rand%0d_len: got timeout %b beats %0d unstable %0d want 0 %0d 0",
                         it, to, obs_d.size() - ob, stab_bad - sb0, 4 * n);
            end
            for (int i = 0; i < exp_d.size() && ob + i < obs_d.size(); i++) begin
                checks++;
                if (obs_d[ob+i] !== exp_d[i] || obs_l[ob+i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d: got %h/%b want %h/%b",
                             it, i, obs_d[ob+i], obs_l[ob+i], exp_d[i], exp_l[i]);
                end
            end
        end
        tr_mode = 0;
    endtask

    task automatic test_reset_mid;
        bit to;
        int sc, ob, k, dc;
        logic [DW-1:0] b1;
        push_rand(2);
        b1 = mq.pop_front();
        ob = obs_d.size();
        dc = done_cnt;
        tr_mode = 0;
        blk_count = '1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (obs_d.size() < ob + 2 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, m_axis_tvalid, m_axis_tlast} !== 3'b0 || m_axis_tdata !== '0) begin
            errors++;
            $display("FAIL reset_async: got b%b v%b l%b data %h want 0",
                     busy, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        checks++;
        if (obs_d.size() - ob != 2 || obs_d[ob] !== b1[127:96] ||
            obs_d[ob+1] !== b1[95:64] || obs_l[ob] !== 1'b0 || obs_l[ob+1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_prefix: got %0d beats want 2 untagged slices of %h",
                     obs_d.size() - ob, b1);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != dc) begin
            errors++;
            $display("FAIL reset_no_done: got %0d done pulses want 0", done_cnt - dc);
        end
        expect_pkt(1);
        ob = obs_d.size();
        run_packet(1, 0, to, sc);
        checks++;
        if (to || obs_d.size() - ob != 4) begin
            errors++;
            $display("FAIL reset_restart: got timeout %b beats %0d want 0 4",
                     to, obs_d.size() - ob);
        end
        for (int i = 0; i < exp_d.size() && ob + i < obs_d.size(); i++) begin
            checks++;
            if (obs_d[ob+i] !== exp_d[i] || obs_l[ob+i] !== exp_l[i]) begin
                errors++;
                $display("FAIL restart_beat%0d: got %h/%b want %h/%b",
                         i, obs_d[ob+i], obs_l[ob+i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_empty_wait();
        test_fifo_ready();
        test_zero();
        test_start_ignored();
        test_random();
        test_reset_mid();
        checks++;
        if (re_bad != 0) begin
            errors++;
            $display("FAIL read_rule: got %0d illegal reads want 0", re_bad);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
